fds_entry_table: RTL and testbench

//  Holds up to DEPTH pending scheduling entries (FDSTI timestamp, FDSSI slot id, wt wait flag).

---
 rtl/fds_pkg.sv | 16 +
 rtl/fds_free_pe.sv | 22 ++
 rtl/fds_entry_table.sv | 105 ++++++++++
 tb/tb_fds_entry_table.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fds_pkg.sv
// fds_pkg: shared defaults and the entry record for the FDS scheduling table.
package fds_pkg;
  localparam int DEF_FDSTI_W = 28;
  localparam int DEF_FDSSI_W = 12;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_IDX_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WT_TIMEOUT = 255;
  typedef struct packed {
    logic                   valid;
    logic                   wt;
    logic [DEF_CNT_W-1:0]   cnt;
    logic [DEF_FDSSI_W-1:0] fdssi;
    logic [DEF_FDSTI_W-1:0] fdsti;
  } entry_t;
endpackage

// File: rtl/fds_free_pe.sv
// fds_free_pe: lowest-index free slot finder over the valid vector.
module fds_free_pe
  import fds_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/fds_entry_table.sv
// fds_entry_table: pending scheduling entries with wait/release/timeout tracking,
// presented as flat registered vectors to the downstream min-compare tree.
module fds_entry_table
  import fds_pkg::*;
#(
  parameter int I_FDSTI_WIDTH = DEF_FDSTI_W,
  parameter int I_FDSSI_WIDTH = DEF_FDSSI_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int WT_TIMEOUT = DEF_WT_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [I_FDSTI_WIDTH-1:0]         wr_fdsti,
  input  logic [I_FDSSI_WIDTH-1:0]         wr_fdssi,
  input  logic                             wr_wt,
  input  logic                             rel_valid,
  input  logic [I_FDSSI_WIDTH-1:0]         rel_fdssi,
  input  logic                             pop_valid,
  input  logic [IDX_W-1:0]                 pop_idx,
  output logic [DEPTH-1:0]                 valid,
  output logic [DEPTH-1:0]                 wt,
  output logic [DEPTH*I_FDSTI_WIDTH-1:0]   FDSTI,
  output logic [DEPTH*I_FDSSI_WIDTH-1:0]   FDSSI,
  output logic [IDX_W:0]                   count,
  output logic                             full,
  output logic                             empty,
  output logic                             err_pop,
  output logic                             timeout_o
);
  typedef struct packed {
    logic                     valid;
    logic                     wt;
    logic [CNT_W-1:0]         cnt;
    logic [I_FDSSI_WIDTH-1:0] fdssi;
    logic [I_FDSTI_WIDTH-1:0] fdsti;
  } slot_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WT_TIMEOUT - 1);
  slot_t ent_q [DEPTH];
  slot_t ent_d [DEPTH];
  logic [DEPTH-1:0] ins, pop, rel, to;
  logic [IDX_W:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, err_pop_q, err_pop_d, timeout_q, timeout_d;
  logic found;
  logic [IDX_W-1:0] free_idx;
  fds_free_pe #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_pe (
    .valid(valid),
    .found(found),
    .idx  (free_idx)
  );
  always_comb begin
    ins = '0;
    pop = '0;
    rel = '0;
    to = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ins[i] = wr_valid & ~full_q & found & (free_idx == IDX_W'(i));
      pop[i] = pop_valid & (pop_idx == IDX_W'(i)) & ent_q[i].valid;
      rel[i] = rel_valid & ent_q[i].valid & (ent_q[i].fdssi == rel_fdssi);
      to[i] = ent_q[i].valid & ent_q[i].wt & ~pop[i] & ~rel[i] & (ent_q[i].cnt == CNT_LAST);
      ent_d[i].valid = ins[i] | (ent_q[i].valid & ~pop[i]);
      ent_d[i].wt = ins[i] ? wr_wt : ent_q[i].wt & ~pop[i] & ~rel[i] & ~to[i];
      ent_d[i].cnt = (!ins[i] && ent_q[i].wt && !pop[i] && !rel[i] && !to[i]) ? ent_q[i].cnt + 1'b1 : '0;
      ent_d[i].fdssi = ins[i] ? wr_fdssi : ent_q[i].fdssi;
      ent_d[i].fdsti = ins[i] ? wr_fdsti : ent_q[i].fdsti;
    end
    count_d = count_q + (IDX_W+1)'(|ins) - (IDX_W+1)'(|pop);
    full_d = count_d == (IDX_W+1)'(DEPTH);
    empty_d = count_d == '0;
    err_pop_d = pop_valid & ~valid[pop_idx];
    timeout_d = |to;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      err_pop_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      err_pop_q <= err_pop_d;
      timeout_q <= timeout_d;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign valid[i] = ent_q[i].valid;
    assign wt[i] = ent_q[i].wt;
    assign FDSTI[i*I_FDSTI_WIDTH +: I_FDSTI_WIDTH] = ent_q[i].fdsti;
    assign FDSSI[i*I_FDSSI_WIDTH +: I_FDSSI_WIDTH] = ent_q[i].fdssi;
  end
  assign count = count_q;
  assign full = full_q;
  assign empty = empty_q;
  assign wr_ready = ~full_q;
  assign err_pop = err_pop_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_fds_entry_table.sv
// tb_fds_entry_table: directed scenarios with hand-computed expectations.
module tb_fds_entry_table;
  localparam int FW = 28;
  localparam int SW = 12;
  localparam int D = 8;
  localparam int IW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, wr_wt = 1'b0, rel_valid = 1'b0, pop_valid = 1'b0;
  logic [FW-1:0] wr_fdsti = '0;
  logic [SW-1:0] wr_fdssi = '0, rel_fdssi = '0;
  logic [IW-1:0] pop_idx = '0;
  logic wr_ready, full, empty, err_pop, timeout_o;
  logic [D-1:0] valid, wt;
  logic [D*FW-1:0] FDSTI;
  logic [D*SW-1:0] FDSSI;
  logic [IW:0] count;
  int n_cmp = 0;
  int n_bad = 0;
  fds_entry_table #(.WT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_fdsti(wr_fdsti), .wr_fdssi(wr_fdssi), .wr_wt(wr_wt),
    .rel_valid(rel_valid), .rel_fdssi(rel_fdssi), .pop_valid(pop_valid), .pop_idx(pop_idx),
    .valid(valid), .wt(wt), .FDSTI(FDSTI), .FDSSI(FDSSI), .count(count),
    .full(full), .empty(empty), .err_pop(err_pop), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic hard_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask
  task automatic insert(input int ti, input int si, input logic w);
    wr_valid = 1'b1;
    wr_fdsti = FW'(ti);
    wr_fdssi = SW'(si);
    wr_wt = w;
    step();
    wr_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (valid !== '0 || wt !== '0) begin n_bad++; $display("FAIL reset_vec valid=%h wt=%h want 0/0", valid, wt); end
    n_cmp++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_flags count=%0d empty=%b full=%b rdy=%b want 0/1/0/1", count, empty, full, wr_ready); end
    n_cmp++; if (FDSTI !== '0 || FDSSI !== '0 || err_pop !== 1'b0 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL reset_data FDSTI/FDSSI/err/to nonzero"); end
    rst_n = 1'b1;
    insert(1, 1, 1'b0);
    insert(2, 2, 1'b1);
    wr_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid !== '0 || count !== '0 || empty !== 1'b1 || wt !== '0) begin n_bad++; $display("FAIL async_reset valid=%h count=%0d empty=%b want 0/0/1", valid, count, empty); end
    wr_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_fill();
    hard_reset();
    for (int i = 0; i < D; i++) insert(100 + i, i, 1'b0);
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (FDSTI[i*FW +: FW] !== FW'(100 + i)) begin n_bad++; $display("FAIL fill_slot%0d fdsti=%0d want %0d", i, FDSTI[i*FW +: FW], 100 + i); end
    end
    n_cmp++; if (count !== 4'd8 || full !== 1'b1 || wr_ready !== 1'b0 || valid !== 8'hFF) begin n_bad++; $display("FAIL fill_flags count=%0d full=%b rdy=%b valid=%h want 8/1/0/ff", count, full, wr_ready, valid); end
    insert(999, 9, 1'b0);
    n_cmp++; if (count !== 4'd8 || FDSTI[0 +: FW] !== FW'(100) || FDSSI[0 +: SW] !== SW'(0)) begin n_bad++; $display("FAIL fill_ninth count=%0d slot0=%0d want 8/100", count, FDSTI[0 +: FW]); end
  endtask
  task automatic test_insert_pop();
    hard_reset();
    for (int i = 0; i < 7; i++) insert(10 + i, i, 1'b0);
    pop_valid = 1'b1;
    pop_idx = 3'd2;
    insert(50, 20, 1'b0);
    pop_valid = 1'b0;
    n_cmp++; if (valid !== 8'b1111_1011 || count !== 4'd7) begin n_bad++; $display("FAIL ins_pop valid=%b count=%0d want 11111011/7", valid, count); end
    n_cmp++; if (FDSTI[7*FW +: FW] !== FW'(50) || err_pop !== 1'b0) begin n_bad++; $display("FAIL ins_pop_slot7 fdsti=%0d err=%b want 50/0", FDSTI[7*FW +: FW], err_pop); end
    insert(60, 21, 1'b0);
    n_cmp++; if (valid !== 8'hFF || full !== 1'b1 || FDSTI[2*FW +: FW] !== FW'(60)) begin n_bad++; $display("FAIL ins_reuse valid=%h full=%b slot2=%0d want ff/1/60", valid, full, FDSTI[2*FW +: FW]); end
  endtask
  task automatic test_release();
    hard_reset();
    insert(1, 5, 1'b1);
    insert(2, 5, 1'b1);
    insert(3, 6, 1'b1);
    n_cmp++; if (wt[2:0] !== 3'b111) begin n_bad++; $display("FAIL rel_pre wt=%b want 111", wt[2:0]); end
    rel_valid = 1'b1;
    rel_fdssi = SW'(5);
    step();
    rel_valid = 1'b0;
    n_cmp++; if (wt[2:0] !== 3'b100 || valid[2:0] !== 3'b111) begin n_bad++; $display("FAIL rel_wt wt=%b valid=%b want 100/111", wt[2:0], valid[2:0]); end
    rel_valid = 1'b1;
    rel_fdssi = SW'(6);
    pop_valid = 1'b1;
    pop_idx = 3'd2;
    step();
    rel_valid = 1'b0;
    pop_valid = 1'b0;
    n_cmp++; if (valid[2:0] !== 3'b011 || wt[2:0] !== 3'b000 || count !== 4'd2 || err_pop !== 1'b0) begin n_bad++; $display("FAIL rel_pop valid=%b wt=%b count=%0d want 011/000/2", valid[2:0], wt[2:0], count); end
  endtask
  task automatic test_timeout();
    hard_reset();
    insert(7, 3, 1'b1);
    n_cmp++; if (wt[0] !== 1'b1 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_ins wt=%b to=%b want 1/0", wt[0], timeout_o); end
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++; if (wt[0] !== 1'b1 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d wt=%b to=%b want 1/0", c, wt[0], timeout_o); end
    end
    step();
    n_cmp++; if (wt[0] !== 1'b0 || timeout_o !== 1'b1 || valid[0] !== 1'b1) begin n_bad++; $display("FAIL to_fire wt=%b to=%b valid=%b want 0/1/1", wt[0], timeout_o, valid[0]); end
    step();
    n_cmp++; if (wt[0] !== 1'b0 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_after wt=%b to=%b want 0/0", wt[0], timeout_o); end
  endtask
  task automatic test_err_pop();
    hard_reset();
    for (int i = 0; i < 5; i++) insert(30 + i, i, 1'b0);
    pop_valid = 1'b1;
    pop_idx = 3'd5;
    step();
    pop_valid = 1'b0;
    n_cmp++; if (err_pop !== 1'b1 || valid !== 8'h1F || count !== 4'd5) begin n_bad++; $display("FAIL err_pop err=%b valid=%h count=%0d want 1/1f/5", err_pop, valid, count); end
    pop_valid = 1'b1;
    pop_idx = 3'd1;
    step();
    pop_valid = 1'b0;
    n_cmp++; if (err_pop !== 1'b0 || valid !== 8'h1D || count !== 4'd4) begin n_bad++; $display("FAIL good_pop err=%b valid=%h count=%0d want 0/1d/4", err_pop, valid, count); end
  endtask
  task automatic test_back_to_back();
    insert(77, 9, 1'b0);
    n_cmp++; if (valid !== 8'h1F || count !== 4'd5 || FDSTI[1*FW +: FW] !== FW'(77) || FDSSI[1*SW +: SW] !== SW'(9)) begin n_bad++; $display("FAIL b2b_reuse valid=%h count=%0d slot1=%0d want 1f/5/77", valid, count, FDSTI[1*FW +: FW]); end
    for (int i = 0; i < 5; i++) begin
      pop_valid = 1'b1;
      pop_idx = IW'(i);
      step();
    end
    pop_valid = 1'b0;
    n_cmp++; if (valid !== '0 || count !== '0 || empty !== 1'b1 || err_pop !== 1'b0) begin n_bad++; $display("FAIL b2b_drain valid=%h count=%0d empty=%b want 0/0/1", valid, count, empty); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_insert_pop();
    test_release();
    test_timeout();
    test_err_pop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
